// File: rtl/lock_key_loader32.sv
// Bit-serial key loader: fetches a 32-bit unlock key over a 4-phase handshake and drives keyinput.
// Define KEYLOAD_CHECK_EN to append and verify a 6-bit popcount checksum (38-bit frame).
module lock_key_loader32 #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic        mem_bit,
  output logic [31:0] key_o,
  output logic        key_valid,
  output logic        busy,
  output logic        err
);

`ifdef KEYLOAD_CHECK_EN
  localparam int unsigned FRAME_LEN = 38;
`else
  localparam int unsigned FRAME_LEN = 32;
`endif
  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, REQ, GAP, CHECK, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] key_o_q, key_o_d;
  logic        key_valid_q, key_valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

`ifdef KEYLOAD_CHECK_EN
  logic [5:0] chk_q, chk_d;
  logic [5:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 32; i++) pop = pop + 6'(shadow_q[i]);
  end
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
`ifdef KEYLOAD_CHECK_EN
    chk_d    = chk_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d  = REQ;
          idx_d    = '0;
          cnt_d    = '0;
          shadow_d = '0;
`ifdef KEYLOAD_CHECK_EN
          chk_d    = '0;
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!idx_q[5]) shadow_d[idx_q[4:0]] = mem_bit;
`ifdef KEYLOAD_CHECK_EN
          else chk_d = {mem_bit, chk_q[5:1]};
`endif
          idx_d   = idx_q + 6'd1;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == TO_LAST) begin
          state_d  = ERR;
          shadow_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (!mem_ack) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
`ifdef KEYLOAD_CHECK_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = REQ;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d  = ERR;
          shadow_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef KEYLOAD_CHECK_EN
      CHECK: begin
        if (pop == chk_q) begin
          state_d = DONE;
        end else begin
          state_d  = ERR;
          shadow_d = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so the bus only ever shows a finished key.
    mem_req_d   = (state_d == REQ);
    busy_d      = (state_d == REQ) || (state_d == GAP) || (state_d == CHECK);
    key_valid_d = (state_d == DONE);
    err_d       = (state_d == ERR);
    key_o_d     = (state_d == DONE) ? shadow_q : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      mem_req_q   <= 1'b0;
      key_o_q     <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      mem_req_q   <= mem_req_d;
      key_o_q     <= key_o_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

`ifdef KEYLOAD_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= '0;
    else        chk_q <= chk_d;
  end
`endif

  assign mem_req   = mem_req_q;
  assign key_o     = key_o_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lock_key_loader32.sv
// Self-checking bench for lock_key_loader32: directed and random loads against a frame-level model.
// Adapts frame length and latency expectations to KEYLOAD_CHECK_EN.
module tb_lock_key_loader32;

  localparam int TIMEOUT = 10;
`ifdef KEYLOAD_CHECK_EN
  localparam int FRAME    = 38;
  localparam int LAT      = 78;
  localparam bit CHECK_EN = 1'b1;
`else
  localparam int FRAME    = 32;
  localparam int LAT      = 65;
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam int M_NORMAL = 0;
  localparam int M_NOACK  = 1;
  localparam int M_STUCK  = 2;
  localparam int M_RESET  = 3;
  localparam int M_START  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_bit = 1'b0;
  logic        mem_req;
  logic [31:0] key_o;
  logic        key_valid;
  logic        busy;
  logic        err;

  int          errors = 0;
  int          checks = 0;

  int          valid_edge;
  int          err_edge;
  int          stall_edge;
  int          ack_count;
  logic        leak;
  logic        hung;
  logic [3:0]  first_flags;
  logic [31:0] first_key;
  logic [35:0] rst_snap;

  always #5 clk = ~clk;

  lock_key_loader32 #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_bit   (mem_bit),
    .key_o     (key_o),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses start, then plays the key store one negedge at a time until the load ends.
  task automatic applyStimulus(input logic [37:0] frame, input int delay, input int mode, input int at_bit);
    int idx;
    int wait_cnt;
    int edges;
    idx = 0; wait_cnt = 0;
    valid_edge = -1; err_edge = -1; stall_edge = -1; ack_count = 0;
    leak = 1'b0; hung = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    first_flags = {mem_req, busy, key_valid, err};
    first_key   = key_o;
    while (edges < 400) begin
      if (key_valid && valid_edge < 0) valid_edge = edges;
      if (err && err_edge < 0) err_edge = edges;
      if (busy && key_o !== 32'h0) leak = 1'b1;
      if (!busy) begin
        hung = 1'b0;
        break;
      end
      if (mode == M_RESET && idx == at_bit && mem_req) begin
        rst_n = 1'b0;
        #1;
        rst_snap = {mem_req, key_valid, busy, err, key_o};
        hung = 1'b0;
        break;
      end
      start = (mode == M_START && idx == at_bit && mem_req);
      if (mem_req && !mem_ack) begin
        if (mode == M_NOACK && idx == at_bit) begin
          if (stall_edge < 0) stall_edge = edges;
        end else if (wait_cnt >= delay) begin
          mem_ack = 1'b1;
          mem_bit = frame[idx];
          ack_count++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else if (!mem_req && mem_ack) begin
        if (mode == M_STUCK && idx == at_bit) begin
          if (stall_edge < 0) stall_edge = edges;
        end else begin
          mem_ack = 1'b0;
          idx++;
        end
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    mem_ack = 1'b0;
    mem_bit = 1'b0;
    checkOutput("load_bound", 64'(hung), 64'd0);
  endtask

  // Reference: a frame is accepted unless checksumming is on and chk differs from the key's popcount.
  task automatic checkLoad(input string tag, input logic [31:0] key, input logic [5:0] chk, input bit timed);
    bit bad;
    bad = CHECK_EN && (int'(chk) != $countones(key));
    checkOutput({tag, "_key"},   64'(key_o),     bad ? 64'd0 : 64'(key));
    checkOutput({tag, "_valid"}, 64'(key_valid), bad ? 64'd0 : 64'd1);
    checkOutput({tag, "_err"},   64'(err),       bad ? 64'd1 : 64'd0);
    checkOutput({tag, "_busy"},  64'(busy),      64'd0);
    checkOutput({tag, "_leak"},  64'(leak),      64'd0);
    checkOutput({tag, "_acks"},  64'(ack_count), 64'(FRAME));
    if (timed) begin
      checkOutput({tag, "_vlat"}, 64'(valid_edge), bad ? 64'(-1) : 64'(LAT));
      checkOutput({tag, "_elat"}, 64'(err_edge),   bad ? 64'(LAT) : 64'(-1));
    end
  endtask

  initial begin
    logic [31:0] k;
    logic [5:0]  c;
    int          d;
    $display("[TB] lock_key_loader32 frame=%0d latency=%0d", FRAME, LAT);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 64'({mem_req, key_valid, busy, err, key_o}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    k = 32'hA5A5_0F0F;
    applyStimulus({6'd16, k}, 0, M_NORMAL, 0);
    checkLoad("happy", k, 6'd16, 1'b1);

    k = 32'h0000_0001;
    applyStimulus({6'd1, k}, 0, M_NORMAL, 0);
    checkOutput("done_restart_flags", 64'(first_flags), 64'(4'b1100));
    checkOutput("done_restart_key", 64'(first_key), 64'd0);
    checkLoad("reload_one", k, 6'd1, 1'b1);

    k = 32'hFFFF_FFFF;
    applyStimulus({6'd31, k}, 0, M_NORMAL, 0);
    checkLoad("bad_chk", k, 6'd31, 1'b1);

    k = 32'h1234_5678;
    applyStimulus({6'($countones(k)), k}, 0, M_START, 3);
    checkLoad("start_in_req", k, 6'($countones(k)), 1'b1);

    applyStimulus({6'd20, 32'hDEAD_BEEF}, 0, M_NOACK, 5);
    checkOutput("to_req_edge", 64'(err_edge), 64'(stall_edge + TIMEOUT));
    checkOutput("to_req_flags", 64'({mem_req, key_valid, busy, err}), 64'(4'b0001));
    checkOutput("to_req_key", 64'(key_o), 64'd0);
    checkOutput("to_req_acks", 64'(ack_count), 64'd5);

    applyStimulus({6'd20, 32'hDEAD_BEEF}, 0, M_STUCK, 5);
    checkOutput("to_gap_edge", 64'(err_edge), 64'(stall_edge + TIMEOUT));
    checkOutput("to_gap_flags", 64'({mem_req, key_valid, busy, err}), 64'(4'b0001));
    checkOutput("to_gap_acks", 64'(ack_count), 64'd6);

    k = 32'h1234_5678;
    applyStimulus({6'($countones(k)), k}, 0, M_NORMAL, 0);
    checkLoad("clean_after_err", k, 6'($countones(k)), 1'b1);

    applyStimulus({6'd0, 32'hFFFF_FFFF}, 0, M_RESET, 17);
    checkOutput("rst_mid_outputs", 64'(rst_snap), 64'd0);
    checkOutput("rst_mid_acks", 64'(ack_count), 64'd17);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    k = 32'h0F0F_3C3C;
    applyStimulus({6'($countones(k)), k}, 0, M_NORMAL, 0);
    checkLoad("after_rst", k, 6'($countones(k)), 1'b1);

    for (int i = 0; i < 16; i++) begin
      k = $urandom;
      d = int'($urandom_range(0, 3));
      c = ($urandom_range(0, 1) == 1) ? 6'($countones(k)) : 6'($urandom);
      applyStimulus({c, k}, d, M_NORMAL, 0);
      checkLoad($sformatf("rand%0d", i), k, c, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
